// File: rtl/reg_file_cfg.sv
// DEPTH x WIDTH register file with programmable config-register reset values, a flattened
// tap bus of the first CFG_REGS registers, and write/read/config/error pulses.
// Optional build: define REG_FILE_PARITY_EN to add per-register even parity checked on read.
module reg_file_cfg #(
  parameter int              ADDRESS  = 4,
  parameter int              DEPTH    = 8,
  parameter int              WIDTH    = 8,
  parameter int              CFG_REGS = 4,
  parameter logic [WIDTH-1:0] RST_VAL2 = 'h81,
  parameter logic [WIDTH-1:0] RST_VAL3 = 'h20
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      WrEn,
  input  logic                      RdEn,
  input  logic [ADDRESS-1:0]        Address,
  input  logic [WIDTH-1:0]          WrData,
  output logic [WIDTH-1:0]          RdData,
  output logic                      RD_D_Vld,
  output logic                      Wr_Ack,
  output logic                      Cfg_Upd,
  output logic                      Cmd_Err,
  output logic [CFG_REGS*WIDTH-1:0] REG_OUT
);

  localparam int               IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDRESS:0] DEPTH_LIM = (ADDRESS + 1)'(DEPTH);
  localparam logic [ADDRESS:0] CFG_LIM   = (ADDRESS + 1)'(CFG_REGS);

  logic [WIDTH-1:0] mem [DEPTH];
`ifdef REG_FILE_PARITY_EN
  logic             par [DEPTH];
  logic             par_err;
`endif

  logic [IDX_W-1:0] idx;
  logic             addr_ok;
  logic             is_cfg;
  logic             do_write;
  logic             do_read;
  logic             illegal;

  function automatic logic [WIDTH-1:0] rst_val(input int k);
    if (k == 2)      return RST_VAL2;
    else if (k == 3) return RST_VAL3;
    else             return '0;
  endfunction

  // Command decode; the widened compare keeps Address = 2**ADDRESS-1 from wrapping.
  assign idx      = Address[IDX_W-1:0];
  assign addr_ok  = {1'b0, Address} < DEPTH_LIM;
  assign is_cfg   = {1'b0, Address} < CFG_LIM;
  assign do_write = WrEn && !RdEn && addr_ok;
  assign do_read  = RdEn && !WrEn && addr_ok;
  assign illegal  = (WrEn && RdEn) || ((WrEn ^ RdEn) && !addr_ok);

`ifdef REG_FILE_PARITY_EN
  assign par_err  = (^mem[idx]) != par[idx];
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the storage is reset on purpose: config consumers need known values right
      // out of reset, so this array is flops with a reset, not an inferable RAM.
      for (int k = 0; k < DEPTH; k++) begin
        mem[k] <= rst_val(k);
`ifdef REG_FILE_PARITY_EN
        par[k] <= ^rst_val(k);
`endif
      end
      RdData   <= '0;
      RD_D_Vld <= 1'b0;
      Wr_Ack   <= 1'b0;
      Cfg_Upd  <= 1'b0;
      Cmd_Err  <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout, so the Cfg_Upd compare below sees the value
      // stored before this edge, not the one being written.
      RD_D_Vld <= 1'b0;
      Wr_Ack   <= 1'b0;
      Cfg_Upd  <= 1'b0;
      Cmd_Err  <= illegal;
      if (do_write) begin
        mem[idx] <= WrData;
`ifdef REG_FILE_PARITY_EN
        par[idx] <= ^WrData;
`endif
        Wr_Ack   <= 1'b1;
        Cfg_Upd  <= is_cfg && (WrData != mem[idx]);
      end
      if (do_read) begin
        RdData   <= mem[idx];
        RD_D_Vld <= 1'b1;
`ifdef REG_FILE_PARITY_EN
        Cmd_Err  <= par_err;
`endif
      end
    end
  end

  for (genvar k = 0; k < CFG_REGS; k++) begin : g_tap
    assign REG_OUT[k*WIDTH +: WIDTH] = mem[k];
  end

endmodule

// File: tb/tb_reg_file_cfg.sv
// Self-checking bench for reg_file_cfg: directed scenarios plus random traffic, every
// cycle compared against an array-based model of the register file's rules.
`timescale 1ns/1ps
module tb_reg_file_cfg;

  localparam int DEPTH    = 8;
  localparam int CFG_REGS = 4;

  logic        clk;
  logic        rst;
  logic        WrEn;
  logic        RdEn;
  logic [3:0]  Address;
  logic [7:0]  WrData;
  logic [7:0]  RdData;
  logic        RD_D_Vld;
  logic        Wr_Ack;
  logic        Cfg_Upd;
  logic        Cmd_Err;
  logic [31:0] REG_OUT;

  reg_file_cfg #(
    .ADDRESS(4), .DEPTH(DEPTH), .WIDTH(8), .CFG_REGS(CFG_REGS),
    .RST_VAL2(8'h81), .RST_VAL3(8'h20)
  ) dut (
    .clk(clk), .rst(rst), .WrEn(WrEn), .RdEn(RdEn), .Address(Address),
    .WrData(WrData), .RdData(RdData), .RD_D_Vld(RD_D_Vld), .Wr_Ack(Wr_Ack),
    .Cfg_Upd(Cfg_Upd), .Cmd_Err(Cmd_Err), .REG_OUT(REG_OUT)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: register contents, last returned read data, corrupted-parity flags.
  logic [7:0] model_mem [DEPTH];
  logic [7:0] model_rd;
  bit         par_bad   [DEPTH];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic model_reset();
    for (int k = 0; k < DEPTH; k++) begin
      model_mem[k] = (k == 2) ? 8'h81 : (k == 3) ? 8'h20 : 8'h00;
      par_bad[k]   = 1'b0;
    end
    model_rd = 8'h00;
  endtask

  function automatic logic [31:0] exp_taps();
    return {model_mem[3], model_mem[2], model_mem[1], model_mem[0]};
  endfunction

  // Drive one command at a negedge, let one posedge pass, check everything at the next negedge.
  task automatic step(input logic wr, input logic rd, input logic [3:0] addr,
                      input logic [7:0] data);
    bit valid, e_ack, e_cfg, e_vld, e_err;
    WrEn = wr; RdEn = rd; Address = addr; WrData = data;
    valid = int'(addr) < DEPTH;
    e_ack = wr && !rd && valid;
    e_cfg = e_ack && int'(addr) < CFG_REGS && data != model_mem[addr[2:0]];
    e_vld = rd && !wr && valid;
    e_err = (wr && rd) || ((wr || rd) && !valid) || (e_vld && par_bad[addr[2:0]]);
    if (e_vld) model_rd = model_mem[addr[2:0]];
    if (e_ack) begin
      model_mem[addr[2:0]] = data;
      par_bad[addr[2:0]]   = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    check("rd_data", 32'(RdData),   32'(model_rd));
    check("rd_vld",  32'(RD_D_Vld), 32'(e_vld));
    check("wr_ack",  32'(Wr_Ack),   32'(e_ack));
    check("cfg_upd", 32'(Cfg_Upd),  32'(e_cfg));
    check("cmd_err", 32'(Cmd_Err),  32'(e_err));
    check("reg_out", REG_OUT,       exp_taps());
  endtask

  task automatic check_all_zero_pulses(input string tag);
    check({tag, "_rd_data"}, 32'(RdData),   32'h0);
    check({tag, "_rd_vld"},  32'(RD_D_Vld), 32'h0);
    check({tag, "_wr_ack"},  32'(Wr_Ack),   32'h0);
    check({tag, "_cfg_upd"}, 32'(Cfg_Upd),  32'h0);
    check({tag, "_cmd_err"}, 32'(Cmd_Err),  32'h0);
    check({tag, "_reg_out"}, REG_OUT,       32'h2081_0000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] a;
    logic [7:0] d;
    logic [1:0] op;
    rst = 1'b1; WrEn = 1'b0; RdEn = 1'b0; Address = '0; WrData = '0;
    model_reset();
    #3 rst = 1'b0;
    #1 check_all_zero_pulses("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Reset values of every register, back-to-back reads.
    for (int k = 0; k < DEPTH; k++) step(1'b0, 1'b1, 4'(k), 8'h00);
    step(1'b0, 1'b0, 4'h0, 8'h00);

    // Config write, same-value rewrite, non-config write, read-back.
    step(1'b1, 1'b0, 4'h1, 8'h5A);
    step(1'b1, 1'b0, 4'h1, 8'h5A);
    step(1'b1, 1'b0, 4'h6, 8'h33);
    step(1'b0, 1'b1, 4'h6, 8'h00);

    // Both enables: nothing happens except Cmd_Err.
    step(1'b1, 1'b1, 4'h3, 8'hFF);
    step(1'b0, 1'b1, 4'h3, 8'h00);

    // Out-of-range addresses, including the top of the address space.
    step(1'b1, 1'b0, 4'h9, 8'h11);
    step(1'b0, 1'b1, 4'h9, 8'h00);
    step(1'b1, 1'b0, 4'hF, 8'h11);
    step(1'b0, 1'b1, 4'h8, 8'h00);
    step(1'b0, 1'b0, 4'h0, 8'h00);

    // Read right after write to the same address.
    step(1'b1, 1'b0, 4'h2, 8'hA5);
    step(1'b0, 1'b1, 4'h2, 8'h00);

`ifdef REG_FILE_PARITY_EN
    dut.mem[4] = dut.mem[4] ^ 8'h01;
    model_mem[4] = model_mem[4] ^ 8'h01;
    par_bad[4] = 1'b1;
`endif
    step(1'b0, 1'b1, 4'h4, 8'h00);

    // Reset asserted in the middle of a read: outputs clear at once, no pulse afterwards.
    WrEn = 1'b0; RdEn = 1'b1; Address = 4'h2;
    #2 rst = 1'b0;
    #1 check_all_zero_pulses("midrst");
    @(posedge clk);
    @(negedge clk);
    check_all_zero_pulses("midrst_hold");
    RdEn = 1'b0;
    rst = 1'b1;
    model_reset();
    step(1'b0, 1'b0, 4'h0, 8'h00);
    step(1'b0, 1'b1, 4'h2, 8'h00);

    // Random traffic; some writes repeat the stored value to exercise the no-change case.
    for (int i = 0; i < 400; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
      d  = ($urandom_range(0, 3) == 0) ? model_mem[a[2:0]] : 8'($urandom);
      case (op)
        2'd0: step(1'b0, 1'b0, a, d);
        2'd1: step(1'b1, 1'b0, a, d);
        2'd2: step(1'b0, 1'b1, a, d);
        default: step(($urandom_range(0, 7) == 0), 1'b1, a, d);
      endcase
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
